// File: rtl/axi_err_slv.sv
// AXI4 default/error responder: accepts every AW/W/AR, discards write data and
// answers each transaction with RespCode on B and R, preserving IDs and burst lengths.

module axi_err_slv_fifo #(
   parameter int unsigned Width = 4,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] head_o
);
   localparam int unsigned PtrW = $clog2(Depth) + 1;

   logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [Width-1:0] mem_q [Depth];
   logic             push_ok, pop_ok;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full_o  = (wr_q[PtrW-1] != rd_q[PtrW-1]) && (wr_q[PtrW-2:0] == rd_q[PtrW-2:0]);
   assign empty_o = (wr_q == rd_q);
   assign head_o  = empty_o ? '0 : mem_q[rd_q[PtrW-2:0]];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_ok) wr_d = wr_q + PtrW'(1);
      if (pop_ok)  rd_d = rd_q + PtrW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q[PtrW-2:0]] <= data_i;
   end
endmodule

module axi_err_slv #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 32,
   parameter logic [1:0]  RespCode  = 2'b11,
   parameter logic [31:0] RespData  = 32'hBADC_AB1E,
   parameter int unsigned MaxTrans  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic [7:0]           aw_len_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [1:0]           b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o
);
   localparam logic [DataWidth-1:0] RData = DataWidth'(RespData);

   typedef enum logic {R_IDLE, R_BURST} r_state_e;

   logic               aw_full, aw_empty, b_full, b_empty;
   logic               w_last_hs;
   logic [IdWidth-1:0] aw_head;
   logic               unused_aw_len;

   // Write bursts are delimited by w_last_i alone, so the AW length is never needed.
   assign unused_aw_len = ^aw_len_i;

   assign aw_ready_o = !aw_full;
   assign w_ready_o  = !aw_empty && !b_full;
   assign w_last_hs  = w_valid_i && w_ready_o && w_last_i;
   assign b_valid_o  = !b_empty;
   assign b_resp_o   = RespCode;

   axi_err_slv_fifo #(.Width(IdWidth), .Depth(MaxTrans)) u_aw_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (aw_valid_i),
      .data_i  (aw_id_i),
      .pop_i   (w_last_hs),
      .full_o  (aw_full),
      .empty_o (aw_empty),
      .head_o  (aw_head)
   );

   axi_err_slv_fifo #(.Width(IdWidth), .Depth(MaxTrans)) u_b_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_last_hs),
      .data_i  (aw_head),
      .pop_i   (b_ready_i),
      .full_o  (b_full),
      .empty_o (b_empty),
      .head_o  (b_id_o)
   );

   r_state_e           state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IdWidth-1:0] id_q, id_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      id_d       = id_q;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      unique case (state_q)
         R_IDLE: begin
            ar_ready_o = 1'b1;
            if (ar_valid_i) begin
               id_d    = ar_id_i;
               cnt_d   = ar_len_i;
               state_d = R_BURST;
            end
         end
         R_BURST: begin
            r_valid_o = 1'b1;
            if (r_ready_i) begin
               if (cnt_q == 8'd0) state_d = R_IDLE;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   assign r_last_o = r_valid_o && (cnt_q == 8'd0);
   assign r_id_o   = id_q;
   assign r_data_o = RData;
   assign r_resp_o = RespCode;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= R_IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
      end
   end
endmodule

// File: tb/tb_axi_err_slv.sv
// Directed bench for axi_err_slv: write path, read bursts, backpressure,
// W-before-AW, asynchronous reset mid-traffic and concurrent read/write traffic.

module tb_axi_err_slv;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        aw_valid_i, aw_ready_o;
   logic [3:0]  aw_id_i;
   logic [7:0]  aw_len_i;
   logic        w_valid_i, w_ready_o, w_last_i;
   logic        b_valid_o, b_ready_i;
   logic [3:0]  b_id_o;
   logic [1:0]  b_resp_o;
   logic        ar_valid_i, ar_ready_o;
   logic [3:0]  ar_id_i;
   logic [7:0]  ar_len_i;
   logic        r_valid_o, r_ready_i;
   logic [3:0]  r_id_o;
   logic [31:0] r_data_o;
   logic [1:0]  r_resp_o;
   logic        r_last_o;

   int checks   = 0;
   int failures = 0;

   axi_err_slv dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .aw_valid_i (aw_valid_i),
      .aw_ready_o (aw_ready_o),
      .aw_id_i    (aw_id_i),
      .aw_len_i   (aw_len_i),
      .w_valid_i  (w_valid_i),
      .w_ready_o  (w_ready_o),
      .w_last_i   (w_last_i),
      .b_valid_o  (b_valid_o),
      .b_ready_i  (b_ready_i),
      .b_id_o     (b_id_o),
      .b_resp_o   (b_resp_o),
      .ar_valid_i (ar_valid_i),
      .ar_ready_o (ar_ready_o),
      .ar_id_i    (ar_id_i),
      .ar_len_i   (ar_len_i),
      .r_valid_o  (r_valid_o),
      .r_ready_i  (r_ready_i),
      .r_id_o     (r_id_o),
      .r_data_o   (r_data_o),
      .r_resp_o   (r_resp_o),
      .r_last_o   (r_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      aw_valid_i = 0; aw_id_i = 0; aw_len_i = 0;
      w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
      ar_valid_i = 0; ar_id_i = 0; ar_len_i = 0; r_ready_i = 0;
      tick(); tick();
      check("rst_aw_ready", aw_ready_o, 1);
      check("rst_w_ready", w_ready_o, 0);
      check("rst_b_valid", b_valid_o, 0);
      check("rst_ar_ready", ar_ready_o, 1);
      check("rst_r_valid", r_valid_o, 0);
      check("rst_r_last", r_last_o, 0);
      check("rst_b_id", b_id_o, 0);
      check("rst_r_id", r_id_o, 0);
      rst_i = 1'b0;
      tick();

      // 1: single write
      aw_valid_i = 1; aw_id_i = 4'd3;
      check("t1_aw_ready", aw_ready_o, 1);
      check("t1_w_ready_pre", w_ready_o, 0);
      tick();
      aw_valid_i = 0;
      check("t1_w_ready", w_ready_o, 1);
      check("t1_b_valid_pre", b_valid_o, 0);
      w_valid_i = 1; w_last_i = 1; b_ready_i = 1;
      tick();
      w_valid_i = 0; w_last_i = 0;
      check("t1_b_valid", b_valid_o, 1);
      check("t1_b_id", b_id_o, 3);
      check("t1_b_resp", b_resp_o, 2'b11);
      check("t1_w_ready_post", w_ready_o, 0);
      tick();
      b_ready_i = 0;
      check("t1_b_idle", b_valid_o, 0);

      // 2: read burst len=3
      ar_valid_i = 1; ar_id_i = 4'd5; ar_len_i = 8'd3;
      check("t2_ar_ready", ar_ready_o, 1);
      tick();
      ar_valid_i = 0; r_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         check("t2_r_valid", r_valid_o, 1);
         check("t2_r_id", r_id_o, 5);
         check("t2_r_data", r_data_o, 32'hBADCAB1E);
         check("t2_r_resp", r_resp_o, 2'b11);
         check("t2_r_last", r_last_o, (i == 3) ? 1 : 0);
         check("t2_ar_ready_busy", ar_ready_o, 0);
         tick();
      end
      r_ready_i = 0;
      check("t2_r_idle", r_valid_o, 0);
      check("t2_ar_ready_idle", ar_ready_o, 1);

      // 3: B backpressure with five writes
      for (int i = 0; i < 4; i++) begin
         aw_valid_i = 1; aw_id_i = 4'(8 + i);
         tick();
         aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
         check("t3_w_ready", w_ready_o, 1);
         tick();
         w_valid_i = 0; w_last_i = 0;
         check("t3_b_head_hold", b_id_o, 8);
      end
      aw_valid_i = 1; aw_id_i = 4'd12;
      tick();
      aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
      check("t3_w_stall", w_ready_o, 0);
      tick();
      check("t3_w_stall2", w_ready_o, 0);
      check("t3_b_valid", b_valid_o, 1);
      check("t3_b_id0", b_id_o, 8);
      b_ready_i = 1;
      tick();
      b_ready_i = 0;
      check("t3_w_unstall", w_ready_o, 1);
      check("t3_b_id1", b_id_o, 9);
      tick();
      w_valid_i = 0; w_last_i = 0;
      check("t3_w_ready_empty", w_ready_o, 0);
      check("t3_b_id1_hold", b_id_o, 9);
      b_ready_i = 1;
      for (int i = 9; i <= 12; i++) begin
         check("t3_b_valid_seq", b_valid_o, 1);
         check("t3_b_id_seq", b_id_o, i);
         tick();
      end
      b_ready_i = 0;
      check("t3_b_drained", b_valid_o, 0);

      // 4: W before AW
      w_valid_i = 1; w_last_i = 1;
      for (int i = 0; i < 3; i++) begin
         check("t4_w_wait", w_ready_o, 0);
         tick();
      end
      aw_valid_i = 1; aw_id_i = 4'd7;
      check("t4_w_wait_aw", w_ready_o, 0);
      tick();
      aw_valid_i = 0;
      check("t4_w_ready", w_ready_o, 1);
      tick();
      w_valid_i = 0; w_last_i = 0;
      check("t4_b_valid", b_valid_o, 1);
      check("t4_b_id", b_id_o, 7);
      b_ready_i = 1;
      tick();
      b_ready_i = 0;
      check("t4_b_idle", b_valid_o, 0);

      // 5: reset in the middle of a read burst with a pending B
      aw_valid_i = 1; aw_id_i = 4'd2;
      tick();
      aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
      tick();
      w_valid_i = 0; w_last_i = 0;
      ar_valid_i = 1; ar_id_i = 4'd4; ar_len_i = 8'd7;
      tick();
      ar_valid_i = 0; r_ready_i = 1;
      tick();
      check("t5_r_valid_pre", r_valid_o, 1);
      check("t5_r_last_pre", r_last_o, 0);
      check("t5_b_valid_pre", b_valid_o, 1);
      rst_i = 1; r_ready_i = 0;
      #1;
      check("t5_r_valid_rst", r_valid_o, 0);
      check("t5_b_valid_rst", b_valid_o, 0);
      check("t5_ar_ready_rst", ar_ready_o, 1);
      check("t5_b_id_rst", b_id_o, 0);
      check("t5_r_id_rst", r_id_o, 0);
      tick();
      rst_i = 0;
      tick();
      ar_valid_i = 1; ar_id_i = 4'd1; ar_len_i = 8'd0;
      tick();
      ar_valid_i = 0;
      check("t5_r_valid", r_valid_o, 1);
      check("t5_r_last", r_last_o, 1);
      check("t5_r_id", r_id_o, 1);
      r_ready_i = 1;
      tick();
      r_ready_i = 0;
      check("t5_r_done", r_valid_o, 0);
      check("t5_b_none", b_valid_o, 0);

      // 6: 256-beat read overlapped with four writes
      ar_valid_i = 1; ar_id_i = 4'd9; ar_len_i = 8'd255;
      tick();
      ar_valid_i = 0; r_ready_i = 1;
      for (int i = 0; i < 256; i++) begin
         aw_valid_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
         if (i < 16) begin
            case (i % 4)
               0: begin aw_valid_i = 1; aw_id_i = 4'(i / 4 + 1); end
               1: begin w_valid_i = 1; w_last_i = 1; end
               2: begin
                  check("t6_b_valid", b_valid_o, 1);
                  check("t6_b_id", b_id_o, i / 4 + 1);
                  b_ready_i = 1;
               end
               default: check("t6_b_idle", b_valid_o, 0);
            endcase
         end
         check("t6_r_valid", r_valid_o, 1);
         check("t6_r_id", r_id_o, 9);
         check("t6_r_last", r_last_o, (i == 255) ? 1 : 0);
         tick();
      end
      aw_valid_i = 0; w_valid_i = 0; w_last_i = 0; b_ready_i = 0; r_ready_i = 0;
      check("t6_r_done", r_valid_o, 0);
      check("t6_ar_ready", ar_ready_o, 1);
      check("t6_b_empty", b_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
